// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, iterative shift-add multiplier and the
// architectural NZCV flag register. Non-multiply results are combinational;
// a multiply holds the stage busy for N+2 cycles and stalls upstream meanwhile.
module execute_stage #(
   parameter int N = 32,
   parameter int M = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_flush_E,
   input  logic         i_regw_E,
   input  logic         i_memw_E,
   input  logic         i_regmem_E,
   input  logic         i_branch_E,
   input  logic         i_ALUope_E,
   input  logic         i_flag_E,
   input  logic [M-1:0] i_ALUctrl_E,
   input  logic [M-1:0] i_regScr_E,
   input  logic [N-1:0] i_regA_E,
   input  logic [N-1:0] i_regB_E,
   input  logic [N-1:0] i_inm_E,
   output logic [N-1:0] o_ALUres_M,
   output logic [N-1:0] o_wdata_M,
   output logic [M-1:0] o_regScr_M,
   output logic         o_regw_M,
   output logic         o_memw_M,
   output logic         o_regmem_M,
   output logic         o_branch_M,
   output logic [3:0]   o_flags,
   output logic         o_stall_E
);

   localparam int SH_W = $clog2(N);

   localparam logic [M-1:0] OP_ADD  = M'(0);
   localparam logic [M-1:0] OP_SUB  = M'(1);
   localparam logic [M-1:0] OP_AND  = M'(2);
   localparam logic [M-1:0] OP_OR   = M'(3);
   localparam logic [M-1:0] OP_XOR  = M'(4);
   localparam logic [M-1:0] OP_SLL  = M'(5);
   localparam logic [M-1:0] OP_SRL  = M'(6);
   localparam logic [M-1:0] OP_SRA  = M'(7);
   localparam logic [M-1:0] OP_MUL  = M'(8);
   localparam logic [M-1:0] OP_CMP  = M'(9);
   localparam logic [M-1:0] OP_MOVB = M'(10);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [N-1:0]    r_acc;
   logic [N-1:0]    r_mcand;
   logic [N-1:0]    r_mplier;
   logic [SH_W-1:0] r_cnt;
   logic [3:0]      r_flags;

   logic [N-1:0]    w_B;
   logic [SH_W-1:0] w_shamt;
   logic [N:0]      w_sum;
   logic [N-1:0]    w_diff;
   logic [N-1:0]    w_alu_res;
   logic            w_alu_c;
   logic            w_alu_v;
   logic [N-1:0]    w_res;
   logic [3:0]      w_flags_next;
   logic            w_stall;
   logic            w_start;
   logic            w_step;
   logic            w_kill;
   logic            w_op_valid;
   logic            w_flag_we;

   assign w_B        = i_ALUope_E ? i_inm_E : i_regB_E;
   assign w_shamt    = w_B[SH_W-1:0];
   assign w_sum      = {1'b0, i_regA_E} + {1'b0, w_B};
   assign w_diff     = i_regA_E - w_B;
   assign w_op_valid = (i_ALUctrl_E <= OP_MOVB);

   // Single-cycle ALU: result plus carry/overflow (C/V hold unless arithmetic)
   always_comb begin
      w_alu_res = '0;
      w_alu_c   = r_flags[1];
      w_alu_v   = r_flags[0];
      case (i_ALUctrl_E)
         OP_ADD: begin
            w_alu_res = w_sum[N-1:0];
            w_alu_c   = w_sum[N];
            w_alu_v   = (i_regA_E[N-1] == w_B[N-1]) && (w_sum[N-1] != i_regA_E[N-1]);
         end
         OP_SUB, OP_CMP: begin
            w_alu_res = w_diff;
            w_alu_c   = (i_regA_E >= w_B);
            w_alu_v   = (i_regA_E[N-1] != w_B[N-1]) && (w_diff[N-1] != i_regA_E[N-1]);
         end
         OP_AND:  w_alu_res = i_regA_E & w_B;
         OP_OR:   w_alu_res = i_regA_E | w_B;
         OP_XOR:  w_alu_res = i_regA_E ^ w_B;
         OP_SLL:  w_alu_res = i_regA_E << w_shamt;
         OP_SRL:  w_alu_res = i_regA_E >> w_shamt;
         OP_SRA:  w_alu_res = $signed(i_regA_E) >>> w_shamt;
         OP_MOVB: w_alu_res = w_B;
         default: w_alu_res = '0;
      endcase
   end

   // Result select and candidate NZCV; the DONE cycle presents the product
   always_comb begin
      w_res        = (r_state == S_DONE) ? r_acc : w_alu_res;
      w_flags_next = {w_res[N-1], (w_res == '0), w_alu_c, w_alu_v};
      if (r_state == S_DONE) begin
         w_flags_next[1:0] = r_flags[1:0];
      end
   end

   // Multiply FSM next-state and stall; flush overrides every state
   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_start      = 1'b0;
      w_step       = 1'b0;
      if (i_flush_E) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_ALUctrl_E == OP_MUL) begin
                  w_start      = 1'b1;
                  w_stall      = 1'b1;
                  w_state_next = S_BUSY;
               end
            end
            S_BUSY: begin
               w_stall = 1'b1;
               w_step  = 1'b1;
               if (r_cnt == SH_W'(N - 1)) begin
                  w_state_next = S_DONE;
               end
            end
            S_DONE: begin
               w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Shift-add multiplier datapath: one partial product per BUSY cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (i_flush_E) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_start) begin
         r_mcand  <= i_regA_E;
         r_mplier <= w_B;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (w_step) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + SH_W'(1);
      end
   end

   assign w_flag_we = i_flag_E && !w_stall && !i_flush_E && w_op_valid;

   // NZCV register: only committed by a live, non-stalled, flag-setting op
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_flags <= '0;
      end else if (w_flag_we) begin
         r_flags <= w_flags_next;
      end
   end

   // Bubble whenever busy, flushed or in reset; CMP never writes a register
   assign w_kill     = w_stall | i_flush_E | i_rst;

   assign o_ALUres_M = w_res;
   assign o_wdata_M  = i_regB_E;
   assign o_regScr_M = i_regScr_E;
   assign o_regw_M   = i_regw_E & ~w_kill & (i_ALUctrl_E != OP_CMP);
   assign o_memw_M   = i_memw_E & ~w_kill;
   assign o_regmem_M = i_regmem_E & ~w_kill;
   assign o_branch_M = i_branch_E & ~w_kill;
   assign o_flags    = r_flags;
   assign o_stall_E  = w_stall & ~i_rst;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: expected results are queued when an
// instruction is driven and compared when the stage presents its output.
module tb_execute_stage;

   logic        clk;
   logic        rst;
   logic        flush_E;
   logic        regw_E, memw_E, regmem_E, branch_E;
   logic        ALUope_E, flag_E;
   logic [3:0]  ALUctrl_E, regScr_E;
   logic [31:0] regA_E, regB_E, inm_E;
   logic [31:0] ALUres_M, wdata_M;
   logic [3:0]  regScr_M;
   logic        regw_M, memw_M, regmem_M, branch_M;
   logic [3:0]  flags;
   logic        stall_E;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  ctl;
      logic        stall;
   } exp_t;

   exp_t        sbq[$];
   int          n_total = 0;
   int          n_bad   = 0;
   logic [3:0]  mflags;

   execute_stage #(.N(32), .M(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush_E(flush_E),
      .i_regw_E(regw_E), .i_memw_E(memw_E), .i_regmem_E(regmem_E), .i_branch_E(branch_E),
      .i_ALUope_E(ALUope_E), .i_flag_E(flag_E), .i_ALUctrl_E(ALUctrl_E), .i_regScr_E(regScr_E),
      .i_regA_E(regA_E), .i_regB_E(regB_E), .i_inm_E(inm_E),
      .o_ALUres_M(ALUres_M), .o_wdata_M(wdata_M), .o_regScr_M(regScr_M),
      .o_regw_M(regw_M), .o_memw_M(memw_M), .o_regmem_M(regmem_M), .o_branch_M(branch_M),
      .o_flags(flags), .o_stall_E(stall_E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] fl);
      logic [32:0]        s;
      logic [31:0]        r;
      logic               c, v;
      logic signed [31:0] sa;
      logic [4:0]         sh;
      c  = fl[1];
      v  = fl[0];
      sh = b[4:0];
      sa = a;
      r  = '0;
      case (op)
         4'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd1, 4'd9: begin
            r = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = a << sh;
         4'd6:  r = a >> sh;
         4'd7:  r = sa >>> sh;
         4'd8:  r = a * b;
         4'd10: r = b;
         default: r = '0;
      endcase
      if (op > 4'd10) return {fl, r};
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ope, input logic [31:0] inm, input logic flg,
                        input logic [3:0] cb, input logic [3:0] dst);
      ALUctrl_E = op;
      regA_E    = a;
      regB_E    = b;
      ALUope_E  = ope;
      inm_E     = inm;
      flag_E    = flg;
      {regw_E, memw_E, regmem_E, branch_E} = cb;
      regScr_E  = dst;
   endtask

   task automatic idle_inputs();
      drive(4'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'b0000, 4'd0);
   endtask

   // Non-multiply op; called at posedge+1, returns at posedge+1 with inputs idle
   task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ope, input logic [31:0] inm, input logic flg,
                         input logic [3:0] cb, input logic [3:0] dst);
      logic [31:0] bsel;
      logic [35:0] m;
      exp_t        e;
      bsel = ope ? inm : b;
      drive(op, a, b, ope, inm, flg, cb, dst);
      m       = model(op, a, bsel, mflags);
      e.res   = m[31:0];
      e.ctl   = {cb[3] & (op != 4'd9), cb[2:0]};
      e.stall = 1'b0;
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      check("res",   ALUres_M, e.res);
      check("ctl",   32'({regw_M, memw_M, regmem_M, branch_M}), 32'(e.ctl));
      check("stall", 32'(stall_E), 32'(e.stall));
      check("wdata", wdata_M, b);
      check("dst",   32'(regScr_M), 32'(dst));
      @(posedge clk);
      #1;
      if (flg && op <= 4'd10) mflags = m[35:32];
      check("flags", 32'(flags), 32'(mflags));
      idle_inputs();
   endtask

   // Multiply held until DONE; expects N+1 stalled cycles then the product
   task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input logic ope,
                         input logic [31:0] inm, input logic flg, input logic [3:0] cb);
      logic [31:0] bsel;
      int          cyc;
      exp_t        e;
      bsel = ope ? inm : b;
      drive(4'd8, a, b, ope, inm, flg, cb, 4'd3);
      e.res   = a * bsel;
      e.ctl   = cb;
      e.stall = 1'b0;
      sbq.push_back(e);
      cyc = 0;
      @(negedge clk);
      while (stall_E && cyc < 100) begin
         if ({regw_M, memw_M, regmem_M, branch_M} != 4'b0000) begin
            check("mul_bubble", 32'({regw_M, memw_M, regmem_M, branch_M}), 32'd0);
         end
         cyc++;
         @(negedge clk);
      end
      check("mul_stall_cycles", 32'(cyc), 32'd33);
      e = sbq.pop_front();
      check("mul_res",   ALUres_M, e.res);
      check("mul_ctl",   32'({regw_M, memw_M, regmem_M, branch_M}), 32'(e.ctl));
      check("mul_stall", 32'(stall_E), 32'(e.stall));
      @(posedge clk);
      #1;
      if (flg) mflags = {e.res[31], (e.res == 32'd0), mflags[1:0]};
      check("mul_flags", 32'(flags), 32'(mflags));
      idle_inputs();
      @(negedge clk);
      check("mul_idle_after", 32'(stall_E), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          cyc;

      mflags  = 4'b0000;
      flush_E = 1'b0;
      rst     = 1'b1;
      drive(4'd8, 32'd4, 32'd4, 1'b0, 32'd0, 1'b1, 4'b1111, 4'd1);
      #2;
      check("rst_stall", 32'(stall_E), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_ctl",   32'({regw_M, memw_M, regmem_M, branch_M}), 32'd0);
      idle_inputs();
      #5 rst = 1'b0;
      @(posedge clk);
      #1;

      // Signed overflow on ADD
      alu_op(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 4'b1000, 4'd2);
      check("add_ovf_flags", 32'(flags), 32'(4'b1001));

      // CMP through the immediate path: no register write
      alu_op(4'd9, 32'd5, 32'd77, 1'b1, 32'd5, 1'b1, 4'b1000, 4'd4);
      check("cmp_flags", 32'(flags), 32'(4'b0110));

      // SRA keeps C/V from the CMP
      alu_op(4'd7, 32'h8000_0000, 32'h0000_0024, 1'b0, 32'd0, 1'b1, 4'b1000, 4'd5);
      check("sra_flags", 32'(flags), 32'(4'b1010));

      // Reserved codes give 0 and leave flags alone
      for (int k = 11; k < 16; k++) begin
         alu_op(4'(k), 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'd0, 1'b1, 4'b1111, 4'(k));
      end

      // Mixed ALU traffic
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         if (op == 4'd8) op = 4'd10;
         a = $urandom();
         b = $urandom();
         if (i % 7 == 0) a = 32'h8000_0000;
         if (i % 5 == 0) b = a;
         alu_op(op, a, b, 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      // Multiplies: wraparound product and zero multiplier
      mul_op(32'hFFFF_FFFF, 32'd3, 1'b0, 32'd0, 1'b1, 4'b1000);
      mul_op(32'd1234, 32'd0, 1'b0, 32'd0, 1'b1, 4'b1010);
      check("mul_zero_Z", 32'(flags[2]), 32'd1);
      mul_op(32'hFFFF_FFFF, 32'd3, 1'b0, 32'd0, 1'b1, 4'b1000);

      // Flush in the middle of BUSY
      drive(4'd8, 32'd7, 32'd9, 1'b0, 32'd0, 1'b1, 4'b1111, 4'd6);
      @(negedge clk);
      check("flush_start_stall", 32'(stall_E), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      flush_E = 1'b1;
      @(negedge clk);
      check("flush_stall", 32'(stall_E), 32'd0);
      check("flush_ctl",   32'({regw_M, memw_M, regmem_M, branch_M}), 32'd0);
      @(posedge clk);
      #1;
      flush_E = 1'b0;
      idle_inputs();
      check("flush_flags", 32'(flags), 32'(mflags));
      @(negedge clk);
      check("flush_idle", 32'(stall_E), 32'd0);
      @(posedge clk);
      #1;

      // Reset during BUSY
      drive(4'd8, 32'd5, 32'd6, 1'b0, 32'd0, 1'b1, 4'b1000, 4'd7);
      @(negedge clk);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mrst_flags", 32'(flags), 32'd0);
      check("mrst_stall", 32'(stall_E), 32'd0);
      check("mrst_regw",  32'(regw_M), 32'd0);
      mflags = 4'b0000;
      idle_inputs();
      #2 rst = 1'b0;
      alu_op(4'd0, 32'd2, 32'd3, 1'b0, 32'd0, 1'b1, 4'b1000, 4'd8);

      // Fresh multiply after reset, multiplier from the immediate
      mul_op(32'd7, 32'd100, 1'b1, 32'd9, 1'b1, 4'b1100);

      // Nothing may remain unconsumed in the scoreboard
      cyc = sbq.size();
      check("sb_empty", 32'(cyc), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits directly downstream of the decode-execute pipeline register and consumes its E-side outputs.
- Contains the single-cycle ALU, an iterative shift-add multiplier, and the architectural NZCV flag register.
- Feeds the execute-memory pipeline register.
- Raises stall_E to the hazard unit while a multiply is in progress.

Parameters:
- N, 32, datapath width in bits
- M, 4, width of ALUctrl and of the register index fields

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush_E  in  1  kill the instruction currently in Execute, including an in-flight multiply
- regw_E, memw_E, regmem_E, branch_E  in  1 each  control bits from the decode-execute register
- ALUope_E  in  1  operand-B select: 1 = inm_E, 0 = regB_E
- flag_E  in  1  instruction updates NZCV
- ALUctrl_E  in  M  operation select
- regScr_E  in  M  destination register index
- regA_E, regB_E, inm_E  in  N each  operands and immediate
- ALUres_M  out  N  ALU or multiply result, to the execute-memory register
- wdata_M  out  N  regB_E pass-through (store data)
- regScr_M  out  M  regScr_E pass-through
- regw_M, memw_M, regmem_M, branch_M  out  1 each  control bits, forced to 0 when bubbled
- flags  out  4  registered {N,Z,C,V}
- stall_E  out  1  hold fetch and decode; Execute is busy

Behaviour:
- Operand B: B = ALUope_E ? inm_E : regB_E. Shift amount = B[$clog2(N)-1:0].
- ALUctrl_E encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA
  - 8 MUL: multi-cycle, low N bits of the product
  - 9 CMP: SUB with regw_M forced 0
  - 10 MOVB: result = B
  - 11-15: result 0, no flag change
- All arithmetic is modulo 2^N.
- Flags are computed from the result:
  - N = res[N-1]; Z = (res == 0).
  - ADD: C = carry-out; V = signed overflow.
  - SUB/CMP: C = not-borrow (A >= B unsigned); V = signed overflow.
  - Logic, shift, MOVB, MUL: C and V hold their previous values.
- Flag register update happens on a clock edge only when flag_E=1, stall_E=0, flush_E=0 and the op is 0-10.
- Non-MUL ops: ALUres_M and all outputs are combinational, with zero added latency.
- Multiply FSM, states IDLE, BUSY, DONE:
  - IDLE, ALUctrl_E=8, flush_E=0: latch mcand=A and mplier=B, clear acc and cnt, go to BUSY. stall_E=1 in this cycle.
  - BUSY: each cycle, if mplier[0] then acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++. When cnt reaches N-1 on a step, go to DONE. BUSY lasts exactly N cycles and stall_E=1 throughout.
  - DONE: ALUres_M = acc, stall_E=0, control bits pass through, flags may update. Always returns to IDLE, even if ALUctrl_E is still 8.
  - Total MUL occupancy is N+2 cycles: 1 start + N busy + 1 done.
- While stall_E=1, the upstream decode stage is held, so the decode-execute register re-captures the same MUL. The FSM ignores ALUctrl_E outside IDLE.
- Bubble rule: while stall_E=1, regw_M, memw_M, regmem_M and branch_M are 0. ALUres_M is don't-care.
- flush_E=1 in any state:
  - FSM goes to IDLE on the next edge; acc and cnt are discarded.
  - stall_E=0 and all four control outputs are 0 in that cycle.
  - Flags are not updated.
- Reset (rst=1, asynchronous), including mid-multiply:
  - State = IDLE, flags = 4'b0000, acc/mcand/mplier/cnt = 0.
  - stall_E is forced 0 while rst is high.
  - Control outputs are 0 while rst is high.
- MUL with B=0: the FSM still runs all N cycles; result = 0, Z=1 in DONE.

Test Plan:
- ADD, A=32'h7FFFFFFF, B=1, flag_E=1 -> ALUres_M=32'h80000000 same cycle; flags next edge N=1, Z=0, C=0, V=1.
- CMP, A=5, inm=5, ALUope_E=1, regw_E=1 -> regw_M=0; flags Z=1, C=1, V=0, N=0.
- MUL, A=32'hFFFFFFFF, B=3, held constant -> stall_E high for 33 cycles, DONE cycle ALUres_M=32'hFFFFFFFD, regw_M=1, stall_E low; the next cycle is in IDLE and does not restart.
- MUL in progress, assert flush_E at BUSY cycle 10 -> stall_E=0 and control outputs 0 that cycle; IDLE next edge; flags unchanged.
- Assert rst mid-multiply (cycle 5 of BUSY) -> immediately flags=0, stall_E=0; after release, a fresh ADD 2+3 gives ALUres_M=5.
- SRA, A=32'h80000000, B=32'h00000024 (amount 4) -> ALUres_M=32'hF8000000; with flag_E=1, C and V are unchanged from prior values.
